// File: rtl/divider.sv
// Integer clock divider: produces clk_N, a square wave with a period of exactly
// N clk cycles, driven straight from a flop so it is glitch-free.
// The low phase is ceil(N/2) cycles and the high phase is floor(N/2) cycles.
module divider #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  output logic clk_N
);

  // N = 0 would also break $clog2, so it is clamped here before the guard below fires.
  localparam int unsigned WIDTH = (N < 2) ? 1 : (($clog2(N) < 1) ? 1 : $clog2(N));
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(N - 1);
  // ceil(N/2): the first count value at which the output is high.
  localparam logic [WIDTH-1:0] HALF    = WIDTH'((N + 1) / 2);

  // A ratio below 2 cannot produce a clock, so reject it when the design is elaborated.
  if (N < 2) begin : g_bad_n
    $error("divider: N must be at least 2");
  end

  // Power-up values match the reset state.
  logic [WIDTH-1:0] cnt_q = '0;
  logic [WIDTH-1:0] cnt_d;
  logic             clk_n_q = 1'b0;
  logic             clk_n_d;

  // Next count wraps at N-1.
  // The output is decoded from the next count, so it changes on the same edge as the count.
  always_comb begin
    cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + WIDTH'(1);
    clk_n_d = (cnt_d >= HALF);
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      clk_n_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clk_n_q <= clk_n_d;
    end
  end

  assign clk_N = clk_n_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider.
// Expected clk_N after k edges since reset release is ((k mod N) >= ceil(N/2)).
module tb_divider;

  logic clk = 1'b0;
  logic rst;
  logic rst10;
  logic c2, c3, c5, c6, c10, c10k;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  divider #(.N(2))     d2   (.clk(clk), .rst(rst),   .clk_N(c2));
  divider #(.N(3))     d3   (.clk(clk), .rst(rst),   .clk_N(c3));
  divider #(.N(5))     d5   (.clk(clk), .rst(rst),   .clk_N(c5));
  divider #(.N(6))     d6   (.clk(clk), .rst(rst),   .clk_N(c6));
  divider #(.N(10))    d10  (.clk(clk), .rst(rst10), .clk_N(c10));
  divider #(.N(10000)) d10k (.clk(clk), .rst(rst),   .clk_N(c10k));

  function automatic logic model(input int k, input int n);
    return ((k % n) >= ((n + 1) / 2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_small(input int k);
    chk($sformatf("n2_k%0d", k), {31'd0, c2}, {31'd0, model(k, 2)});
    chk($sformatf("n3_k%0d", k), {31'd0, c3}, {31'd0, model(k, 3)});
    chk($sformatf("n5_k%0d", k), {31'd0, c5}, {31'd0, model(k, 5)});
    chk($sformatf("n6_k%0d", k), {31'd0, c6}, {31'd0, model(k, 6)});
  endtask

  initial begin
    int rises[$];
    int falls[$];
    int rise5;
    logic prev;
    int hold;
    int len;

    rst   = 1'b1;
    rst10 = 1'b1;
    #1;
    chk("reset_n2",  {31'd0, c2},   32'd0);
    chk("reset_n3",  {31'd0, c3},   32'd0);
    chk("reset_n6",  {31'd0, c6},   32'd0);
    chk("reset_n10", {31'd0, c10},  32'd0);
    chk("reset_n10k",{31'd0, c10k}, 32'd0);

    // Main run: all dividers released together, N=10000 for 30000 edges.
    @(negedge clk);
    rst   = 1'b0;
    rst10 = 1'b0;
    prev  = 1'b0;
    rise5 = 0;
    for (int k = 1; k <= 30000; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n10k_k%0d", k), {31'd0, c10k}, {31'd0, model(k, 10000)});
      if (c10k && !prev) rises.push_back(k);
      if (!c10k && prev) falls.push_back(k);
      prev = c10k;
      if (k <= 1000) begin
        chk_small(k);
        chk($sformatf("n6_cnt_k%0d", k), {31'd0, (d6.cnt_q <= 3'd5)}, 32'd1);
        chk($sformatf("n10_k%0d", k), {31'd0, c10}, {31'd0, model(k, 10)});
      end
      if (k <= 15 && c5 && rise5 == 0) rise5 = k;
    end
    chk("n10k_nrises",  rises.size(), 32'd3);
    chk("n10k_rise0",   rises[0], 32'd5000);
    chk("n10k_rise1",   rises[1], 32'd15000);
    chk("n10k_rise2",   rises[2], 32'd25000);
    chk("n10k_fall0",   falls[0], 32'd10000);
    chk("n10k_fall1",   falls[1], 32'd20000);
    chk("n10k_high",    falls[0] - rises[0], 32'd5000);
    chk("n10k_low",     rises[1] - falls[0], 32'd5000);
    chk("n5_first_rise", rise5, 32'd3);

    // Mid-operation reset on N=10: restart, run to edge 7 (high), then reset between edges.
    @(negedge clk);
    rst10 = 1'b1;
    @(negedge clk);
    rst10 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n10_pre_k%0d", k), {31'd0, c10}, {31'd0, model(k, 10)});
    end
    #1;
    rst10 = 1'b1;
    #1;
    chk("n10_async_clk", {31'd0, c10}, 32'd0);
    chk("n10_async_cnt", {28'd0, d10.cnt_q}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n10_hold_k%0d", k), {31'd0, c10}, 32'd0);
    end
    @(negedge clk);
    rst10 = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n10_post_k%0d", k), {31'd0, c10}, {31'd0, model(k, 10)});
    end

    // Randomised resets: random assert phase, hold length and run length.
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      #($urandom_range(0, 4));
      rst   = 1'b1;
      rst10 = 1'b1;
      #1;
      chk($sformatf("rnd%0d_async_n3", r),  {31'd0, c3},   32'd0);
      chk($sformatf("rnd%0d_async_n10k", r),{31'd0, c10k}, 32'd0);
      hold = $urandom_range(1, 5);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      rst10 = 1'b0;
      len = $urandom_range(1, 40);
      for (int k = 1; k <= len; k++) begin
        @(posedge clk);
        #1;
        chk_small(k);
        chk($sformatf("rnd_n10_k%0d", k), {31'd0, c10}, {31'd0, model(k, 10)});
        chk($sformatf("rnd_n10k_k%0d", k), {31'd0, c10k}, {31'd0, model(k, 10000)});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
